mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Memory-side responder for the cache arbiter's line-transfer port (strobe/addr/rw/dout in, done/din out).
- Accepts one cache-line request at a time (DATA_WIDTH bits) and performs it as a sequence of word accesses on a synchronous word-wide RAM port (BRAM or equivalent, 1-cycle read latency).
- Pulses done when the line is written, or when the whole line has been read back.
- Sits between the arbiter and on-chip main memory. Also serves as the functional memory model in arbiter/cache simulations.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the request and memory ports.
- DATA_WIDTH, 256, cache-line width.
- WORD_WIDTH, 32, memory word width. N = DATA_WIDTH/WORD_WIDTH is the beat count; N must be a power of two and ≥2 (default 8).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- s_strobe  input  1  line request; held high by the requester until s_done.
- s_addr  input  ADDR_WIDTH  line byte address; low log2(DATA_WIDTH/8) bits are ignored.
- s_rw  input  1  1 = write line to memory, 0 = read line.
- s_din  input  DATA_WIDTH  write line data.
- s_done  output  1  one-cycle completion pulse.
- s_dout  output  DATA_WIDTH  read line data.
- busy  output  1  a transaction is in progress (state ≠ IDLE).
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_WIDTH  RAM word byte address.
- mem_wdata  output  WORD_WIDTH  RAM write data.
- mem_rdata  input  WORD_WIDTH  RAM read data, valid the cycle after a read is issued.

Behaviour:
- Reset: state = IDLE, beat counter = 0. All outputs are registered and reset to 0: s_done, s_dout, busy, mem_en, mem_we, mem_addr, mem_wdata.
- States: IDLE, WR, RD, RD_LAST, DONE.
- IDLE:
  - On s_strobe=1, latch base = s_addr with the low log2(DATA_WIDTH/8) bits cleared, latch s_rw, and latch s_din (write only).
  - Clear the beat counter and go to WR if s_rw=1, else RD.
  - s_strobe=0 keeps the block in IDLE.
- Beat k (0..N-1) accesses word address base + k*(WORD_WIDTH/8) and maps to line bits [k*WORD_WIDTH +: WORD_WIDTH], word 0 in the LSBs.
- WR:
  - Each cycle drives mem_en=1, mem_we=1, mem_addr for beat k, mem_wdata = latched word k.
  - Increment k. After beat N-1 is driven, go to DONE.
- RD:
  - Each cycle drives mem_en=1, mem_we=0, mem_addr for beat k.
  - mem_rdata returned the following cycle is written into s_dout word k-1.
  - After beat N-1 is issued, go to RD_LAST (mem_en=0) to capture the final word, then go to DONE.
- DONE:
  - s_done=1 for exactly this cycle; mem_en=0. Next state is IDLE unconditionally.
  - The requester drops s_strobe on the edge that ends DONE, so a stale strobe is never re-accepted.
- Latency, with s_strobe first seen in IDLE in cycle T:
  - Write: RAM beats in T+1..T+N, s_done in T+N+1.
  - Read: issues in T+1..T+N, captures in T+2..T+N+1, s_done in T+N+2.
  - Defaults: write done at T+9, read done at T+10.
- s_dout:
  - Valid during the s_done cycle and holds its value until the next read's first capture.
  - Write transactions leave it unchanged.
- Request inputs: s_addr/s_rw/s_din changing after acceptance have no effect; the latched copies are used.
- Back-to-back: a new strobe can be accepted in the first IDLE cycle after DONE. Minimum request spacing is therefore N+2 cycles (write) or N+3 cycles (read).
- Reset mid-transaction:
  - The in-flight transaction is abandoned; no s_done is generated.
  - mem_en/mem_we are low from the cycle after the reset edge.
  - RAM words already written stay written (a partial line is acceptable).
- Address wrap: the beat address is computed as base + offset in ADDR_WIDTH bits. Because base is line-aligned, beats never cross a line boundary.

Test Plan:
- Reset → all outputs 0 and busy=0. Hold s_strobe=0 for 20 cycles → mem_en stays 0.
- Write s_addr=0x0000_1004 (offset ignored → base 0x1000), s_din words 0x11111111..0x88888888:
  - mem writes at 0x1000..0x101C in cycles T+1..T+8 with matching data, s_done=1 only in T+9.
- Read of 0x1000 after that write:
  - s_dout = {0x88888888,…,0x11111111} (word 0 in LSBs), s_done=1 only in T+10, mem_en=0 in T+9/T+10.
- Mimic the arbiter (strobe falls on the edge ending done; new strobe follows immediately):
  - Exactly one s_done per request, no duplicate transaction, second request accepted the cycle after DONE.
- rst asserted during write beat 4:
  - No s_done, mem_en=0 from the next cycle, state IDLE.
  - A subsequent read of that line returns new words 0..3 and old words 4..7 (as driven at the reset edge).
- Change s_addr/s_din during a write in progress → RAM receives only the originally latched address and data.

Source files
------------

// File: rtl/mem_line_responder.sv
// Memory-side responder for the cache arbiter's line port: splits one cache-line
// request into word beats on a synchronous RAM port with one-cycle read latency.
module mem_line_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_strobe,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic                  s_rw,
  input  logic [DATA_WIDTH-1:0] s_din,
  output logic                  s_done,
  output logic [DATA_WIDTH-1:0] s_dout,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  localparam int unsigned N         = DATA_WIDTH / WORD_WIDTH;
  localparam int unsigned IdxW      = $clog2(N);
  localparam int unsigned CntW      = IdxW + 1;
  localparam int unsigned WordShift = $clog2(WORD_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);
  localparam logic [CntW-1:0]       LastCnt = CntW'(N);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRdLast, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] line_q, line_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [IdxW-1:0]       beat_idx;
  logic [IdxW-1:0]       cap_idx;

  // cnt_q counts beats already placed on the RAM port; it doubles as the next beat index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    line_d    = line_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    beat_addr = base_q + (ADDR_WIDTH'(cnt_q) << WordShift);
    beat_idx  = cnt_q[IdxW-1:0];
    cap_idx   = '0;

    unique case (state_q)
      StIdle: begin
        if (s_strobe) begin
          base_d = s_addr & ~OffMask;
          addr_d = s_addr & ~OffMask;
          cnt_d  = CntW'(1);
          en_d   = 1'b1;
          if (s_rw) begin
            line_d  = s_din;
            we_d    = 1'b1;
            wdata_d = s_din[WORD_WIDTH-1:0];
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StWr: begin
        if (cnt_q == LastCnt) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          en_d    = 1'b1;
          we_d    = 1'b1;
          addr_d  = beat_addr;
          wdata_d = line_q[beat_idx*WORD_WIDTH +: WORD_WIDTH];
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StRd: begin
        // Data on mem_rdata belongs to the beat issued two counts back.
        if (cnt_q >= CntW'(2)) begin
          cap_idx = IdxW'(cnt_q - CntW'(2));
          dout_d[cap_idx*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
        end
        if (cnt_q == LastCnt) begin
          state_d = StRdLast;
        end else begin
          en_d   = 1'b1;
          addr_d = beat_addr;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      StRdLast: begin
        dout_d[(N-1)*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
      line_q  <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      line_q  <= line_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign s_done    = done_q;
  assign s_dout    = dout_q;
  assign busy      = busy_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder with a small synchronous RAM model.
module tb_mem_line_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_strobe;
  logic [31:0]  s_addr;
  logic         s_rw;
  logic [255:0] s_din;
  logic         s_done;
  logic [255:0] s_dout;
  logic         busy;
  logic         mem_en;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata = '0;

  int total = 0;
  int bad = 0;
  int stray_wr = 0;

  logic [31:0] ram [16384];

  always #5 clk = ~clk;

  mem_line_responder dut (
    .clk       (clk),
    .rst       (rst),
    .s_strobe  (s_strobe),
    .s_addr    (s_addr),
    .s_rw      (s_rw),
    .s_din     (s_din),
    .s_done    (s_done),
    .s_dout    (s_dout),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[15:2]] <= mem_wdata;
        if (mem_addr[31:12] == 20'h3) stray_wr <= stray_wr + 1;
      end else begin
        mem_rdata <= ram[mem_addr[15:2]];
      end
    end
  end

  // Issue one request and hold strobe until done, then drop it on the edge ending done.
  task automatic run_req(input logic rw, input logic [31:0] addr, input logic [255:0] din);
    bit seen;
    @(negedge clk);
    s_addr = addr; s_rw = rw; s_din = din; s_strobe = 1'b1;
    seen = 1'b0;
    for (int j = 1; j <= 20 && !seen; j++) begin
      @(negedge clk);
      if (s_done) begin
        seen = 1'b1;
        s_strobe = 1'b0;
      end
    end
    s_strobe = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL req_timeout: done seen=%0d required=1 addr=%h", seen, addr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; s_strobe = 1'b0; s_addr = '0; s_rw = 1'b0; s_din = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({s_done, busy, mem_en, mem_we} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0
        || s_dout !== '0) begin
      bad++;
      $display("FAIL reset_outputs: done=%b busy=%b en=%b we=%b addr=%h wdata=%h required all 0",
               s_done, busy, mem_en, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      total++;
      if (mem_en !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet: cycle %0d en=%b busy=%b required 0 0", j, mem_en, busy);
      end
    end
  endtask

  task automatic test_write;
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'h11111111 * (i + 1);
    @(negedge clk);
    s_addr = 32'h0000_1004; s_rw = 1'b1; s_din = w; s_strobe = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      total++;
      if (mem_en !== (j <= 8) || s_done !== (j == 9)) begin
        bad++;
        $display("FAIL wr_ctrl: T+%0d en=%b done=%b required %b %b", j, mem_en, s_done,
                 (j <= 8), (j == 9));
      end
      if (j <= 8) begin
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h1000 + 4 * (j - 1)
            || mem_wdata !== 32'h11111111 * j) begin
          bad++;
          $display("FAIL wr_beat: T+%0d we=%b addr=%h data=%h required 1 %h %h", j, mem_we,
                   mem_addr, mem_wdata, 32'h1000 + 4 * (j - 1), 32'h11111111 * j);
        end
      end
      if (j == 9) begin
        s_strobe = 1'b0;
        total++;
        if (s_dout !== '0) begin
          bad++;
          $display("FAIL wr_dout_kept: got %h required 0", s_dout);
        end
      end
      if (j >= 10) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL wr_no_reaccept: T+%0d busy=%b required 0", j, busy);
        end
      end
    end
  endtask

  task automatic test_read;
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'h11111111 * (i + 1);
    @(negedge clk);
    s_addr = 32'h0000_1000; s_rw = 1'b0; s_din = {8{32'hDEADBEEF}}; s_strobe = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      total++;
      if (mem_en !== (j <= 8) || s_done !== (j == 10)) begin
        bad++;
        $display("FAIL rd_ctrl: T+%0d en=%b done=%b required %b %b", j, mem_en, s_done,
                 (j <= 8), (j == 10));
      end
      if (j <= 8) begin
        total++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h1000 + 4 * (j - 1)) begin
          bad++;
          $display("FAIL rd_beat: T+%0d we=%b addr=%h required 0 %h", j, mem_we, mem_addr,
                   32'h1000 + 4 * (j - 1));
        end
      end
      if (j >= 10) begin
        s_strobe = 1'b0;
        total++;
        if (s_dout !== w) begin
          bad++;
          $display("FAIL rd_data: T+%0d got %h required %h", j, s_dout, w);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [255:0] x;
    int dones, first_at, second_at;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = 32'hA5A50000 + 32'(i * 3);
    dones = 0; first_at = -1; second_at = -1;
    @(negedge clk);
    s_addr = 32'h0000_4000; s_rw = 1'b1; s_din = x; s_strobe = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (s_done) begin
        dones++;
        if (dones == 1) begin
          first_at = j;
          s_rw = 1'b0; s_din = '0;
        end else if (dones == 2) begin
          second_at = j;
          s_strobe = 1'b0;
        end
      end
    end
    s_strobe = 1'b0;
    total++;
    if (dones != 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d done pulses required 2", dones);
    end
    total++;
    if (first_at != 9 || second_at != 20) begin
      bad++;
      $display("FAIL b2b_timing: done at %0d,%0d required 9,20", first_at, second_at);
    end
    total++;
    if (s_dout !== x) begin
      bad++;
      $display("FAIL b2b_data: got %h required %h", s_dout, x);
    end
  endtask

  task automatic test_latch;
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'hC0DE0000 + 32'(i);
    @(negedge clk);
    s_addr = 32'h0000_2010; s_rw = 1'b1; s_din = w; s_strobe = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 2) begin
        s_addr = 32'h0000_3000; s_din = '1; s_rw = 1'b0;
      end
      if (j <= 8) begin
        total++;
        if (mem_addr !== 32'h2000 + 4 * (j - 1) || mem_wdata !== 32'hC0DE0000 + 32'(j - 1)) begin
          bad++;
          $display("FAIL latch_beat: T+%0d addr=%h data=%h required %h %h", j, mem_addr,
                   mem_wdata, 32'h2000 + 4 * (j - 1), 32'hC0DE0000 + 32'(j - 1));
        end
      end
      if (j == 9) s_strobe = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ram[14'h800 + 14'(i)] !== 32'hC0DE0000 + 32'(i)) begin
        bad++;
        $display("FAIL latch_ram: word %0d got %h required %h", i, ram[14'h800 + 14'(i)],
                 32'hC0DE0000 + 32'(i));
      end
    end
    total++;
    if (stray_wr != 0) begin
      bad++;
      $display("FAIL latch_stray: got %0d writes to 0x3xxx required 0", stray_wr);
    end
  endtask

  task automatic test_reset_mid;
    logic [255:0] old_l, new_l, exp_l;
    int dones;
    for (int i = 0; i < 8; i++) begin
      old_l[i*32 +: 32] = 32'h0DD00000 + 32'(i);
      new_l[i*32 +: 32] = 32'hBEEF0000 + 32'(i);
      exp_l[i*32 +: 32] = (i < 4) ? 32'hBEEF0000 + 32'(i) : 32'h0DD00000 + 32'(i);
    end
    run_req(1'b1, 32'h0000_5000, old_l);
    @(negedge clk);
    s_addr = 32'h0000_5000; s_rw = 1'b1; s_din = new_l; s_strobe = 1'b1;
    repeat (4) @(negedge clk);
    // Beat 3 is on the port now; the reset edge is the one that would launch beat 4.
    rst = 1'b1;
    s_strobe = 1'b0;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || s_done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_outputs: en=%b we=%b busy=%b done=%b required 0 0 0 0", mem_en,
               mem_we, busy, s_done);
    end
    rst = 1'b0;
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (s_done || busy) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL rstmid_idle: got %0d active cycles required 0", dones);
    end
    run_req(1'b0, 32'h0000_5000, '0);
    total++;
    if (s_dout !== exp_l) begin
      bad++;
      $display("FAIL rstmid_data: got %h required %h", s_dout, exp_l);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_latch;
    test_reset_mid;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
